// File: rtl/baby_kyber_pkg.sv
// Shared ring parameters, coefficient/polynomial types and mod-Q helpers
// for the Baby Kyber datapath.
package baby_kyber_pkg;

  localparam int N     = 4;
  localparam int Q     = 17;
  localparam int K     = 2;
  localparam int W     = 32;
  localparam int CNT_W = $clog2(K + 1);

  typedef logic signed [W-1:0] coeff_t;
  typedef coeff_t [N-1:0]      poly_t;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic signed [W:0] Q_EXT = (W+1)'(Q);

  // One conditional subtract is enough because both operands are already in [0,Q-1].
  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
    logic signed [W:0] s;
    s = (W+1)'(a) + (W+1)'(b);
    if (s >= Q_EXT) s = s - Q_EXT;
    return coeff_t'(s[W-1:0]);
  endfunction

  function automatic logic in_range(input coeff_t c);
    return (c >= 0) && (c < coeff_t'(Q));
  endfunction

  function automatic coeff_t coeff_clean(input coeff_t c);
    return in_range(c) ? c : '0;
  endfunction

endpackage

// File: rtl/mod_q_adder.sv
// N-lane combinational adder: each lane returns (a + b) mod Q for in-range operands.
module mod_q_adder
  import baby_kyber_pkg::*;
(
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [N*W-1:0] sum
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign sum[i*W +: W] = mod_add(a[i*W +: W], b[i*W +: W]);
  end

endmodule

// File: rtl/poly_vec_accumulator.sv
// Sums a stream of reduced product polynomials mod Q, optionally adds a bias on
// the closing term, and holds the result behind a valid/ready handshake.
module poly_vec_accumulator
  import baby_kyber_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [N*W-1:0]   in_poly,
  input  logic             bias_en,
  input  logic [N*W-1:0]   bias_poly,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   out_poly,
  output logic [CNT_W-1:0] out_terms,
  output logic             len_err,
  output logic             range_err
);

  state_t           state, state_next;
  logic [N*W-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic [N*W-1:0]   in_clean, bias_clean, acc_base, acc_sum, res;
  logic             accept, at_limit, closing, in_bad, bias_bad;

  // Handshake decode uses the state directly so the FSM process stays loop-free.
  assign accept   = in_valid && (state == ST_ACC);
  assign at_limit = (cnt + CNT_W'(1)) == CNT_W'(K);
  assign closing  = accept && (in_last || at_limit);

  // Out-of-range coefficients are zeroed here and flagged; bias only matters when enabled.
  always_comb begin
    in_clean   = '0;
    bias_clean = '0;
    in_bad     = 1'b0;
    bias_bad   = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_clean[i*W +: W] = coeff_clean(in_poly[i*W +: W]);
      in_bad             = in_bad | !in_range(in_poly[i*W +: W]);
      if (bias_en) begin
        bias_clean[i*W +: W] = coeff_clean(bias_poly[i*W +: W]);
        bias_bad             = bias_bad | !in_range(bias_poly[i*W +: W]);
      end
    end
  end

  // First term of a run adds onto zero, which makes acc = in_poly without a separate mux.
  assign acc_base = (cnt == '0) ? '0 : acc;

  mod_q_adder u_acc_add (
    .a   (acc_base),
    .b   (in_clean),
    .sum (acc_sum)
  );

  mod_q_adder u_bias_add (
    .a   (acc_sum),
    .b   (bias_clean),
    .sum (res)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (closing) state_next = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_ACC;
      end
      default: state_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      out_poly  <= '0;
      out_terms <= '0;
      len_err   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state     <= state_next;
      len_err   <= closing && !in_last;
      range_err <= accept && (in_bad || (closing && bias_bad));
      if (closing) begin
        acc       <= '0;
        cnt       <= '0;
        out_poly  <= res;
        out_terms <= cnt + CNT_W'(1);
      end else if (accept) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_poly_vec_accumulator.sv
// Scoreboard bench for poly_vec_accumulator: directed cases then randomized traffic
// against an integer-arithmetic reference model.
module tb_poly_vec_accumulator;
  import baby_kyber_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last, bias_en;
  logic [N*W-1:0]   in_poly, bias_poly, out_poly;
  logic             out_valid, out_ready;
  logic [CNT_W-1:0] out_terms;
  logic             len_err, range_err;

  poly_vec_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_poly   (in_poly),
    .bias_en   (bias_en),
    .bias_poly (bias_poly),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_poly  (out_poly),
    .out_terms (out_terms),
    .len_err   (len_err),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] poly;
    int             terms;
    int             due;
  } res_t;

  res_t exp_q[$];
  int   range_q[$];
  int   len_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int stall    = 0;
  bit rnd_ready = 0;
  bit shown     = 0;

  int part[N];
  int pcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) part[i] = 0;
    pcnt = 0;
  endfunction

  function automatic bit bad_coef(input int c);
    return (c < 0) || (c >= Q);
  endfunction

  // Drive one beat, wait (bounded) for acceptance, and update the reference model.
  task automatic send(input int c[N], input bit last, input bit ben, input int b[N]);
    int   guard;
    bit   closing, bad;
    res_t r;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      in_poly[i*W +: W]   = c[i];
      bias_poly[i*W +: W] = b[i];
    end
    in_last  = last;
    bias_en  = ben;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    closing = last || (pcnt + 1 == K);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (bad_coef(c[i])) bad = 1;
      else part[i] += c[i];
    end
    if (closing && ben) begin
      for (int i = 0; i < N; i++) begin
        if (bad_coef(b[i])) bad = 1;
        else part[i] += b[i];
      end
    end
    pcnt++;
    if (bad) range_q.push_back(cyc + 1);
    if (closing) begin
      r.poly = '0;
      for (int i = 0; i < N; i++) r.poly[i*W +: W] = part[i] % Q;
      r.terms = pcnt;
      r.due   = cyc + 1;
      exp_q.push_back(r);
      if (!last) len_q.push_back(cyc + 1);
      model_clear();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    bias_en  = 1'b0;
  endtask

  function automatic int rand_coef();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return -int'($urandom_range(1, 5));
    if (r == 1) return int'($urandom_range(Q, Q + 20));
    return int'($urandom_range(0, Q - 1));
  endfunction

  // Monitor and sink: compares every presented result and pulse against the scoreboard.
  always @(negedge clk) begin
    bit e, nr;
    if (!rst) begin
      e = (range_q.size() > 0) && (range_q[0] == cyc);
      if (e) void'(range_q.pop_front());
      check("range_err", range_err, e);
      e = (len_q.size() > 0) && (len_q[0] == cyc);
      if (e) void'(len_q.pop_front());
      check("len_err", len_err, e);

      if (out_valid && stall > 0) begin
        nr = 1'b0;
        stall--;
      end else begin
        nr = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      if (out_valid) begin
        check("in_ready_in_out", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          check("out_poly", out_poly, exp_q[0].poly);
          check("out_terms", out_terms, exp_q[0].terms);
          if (!shown) check("latency", cyc, exp_q[0].due);
          shown = 1;
          if (nr) begin
            void'(exp_q.pop_front());
            shown = 0;
          end
        end
      end
      out_ready = nr;
    end
  end

  initial begin
    int z[N];
    int a[N], b[N];
    int guard;
    for (int i = 0; i < N; i++) z[i] = 0;
    model_clear();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    bias_en   = 1'b0;
    in_poly   = '0;
    bias_poly = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_poly", out_poly, 0);
    check("rst_out_terms", out_terms, 0);
    check("rst_len_err", len_err, 0);
    check("rst_range_err", range_err, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Basic two-term sum, then with bias on the closing beat.
    send('{16, 16, 16, 16}, 0, 0, z);
    send('{1, 2, 3, 4}, 1, 0, z);
    send('{16, 16, 16, 16}, 0, 1, '{9, 9, 9, 9});
    send('{1, 2, 3, 4}, 1, 1, '{5, 0, 0, 16});
    // Single term, and a run closed by the term limit.
    send('{3, 0, 9, 1}, 1, 0, z);
    send('{4, 5, 6, 7}, 0, 0, z);
    send('{10, 12, 11, 16}, 0, 0, z);
    // Held result while the consumer stalls.
    stall = 5;
    send('{8, 8, 8, 8}, 1, 0, z);
    send('{1, 0, 0, 0}, 1, 0, z);
    // Out-of-range coefficient is dropped and flagged.
    send('{17, 1, 1, 1}, 0, 0, z);
    send('{2, 2, 2, 2}, 1, 0, z);

    // Reset mid-accumulation discards the partial sum.
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    send('{5, 5, 5, 5}, 0, 0, z);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_poly", out_poly, 0);
    check("midrst_out_terms", out_terms, 0);
    check("midrst_in_ready", in_ready, 1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    send('{1, 1, 1, 1}, 0, 0, z);
    send('{2, 2, 2, 2}, 1, 0, z);

    // Randomized traffic with random back-pressure.
    rnd_ready = 1;
    for (int t = 0; t < 150; t++) begin
      int nt;
      nt = int'($urandom_range(1, K));
      if ($urandom_range(0, 9) == 0) stall = int'($urandom_range(1, 6));
      for (int j = 0; j < nt; j++) begin
        bit lst;
        if (j != nt - 1) lst = 0;
        else if (nt < K) lst = 1;
        else lst = $urandom_range(0, 1) != 0;
        for (int i = 0; i < N; i++) begin
          a[i] = rand_coef();
          b[i] = rand_coef();
        end
        send(a, lst, $urandom_range(0, 1) != 0, b);
      end
    end

    guard = 0;
    while ((exp_q.size() > 0 || range_q.size() > 0 || len_q.size() > 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_results", exp_q.size(), 0);
    check("drain_pulses", range_q.size() + len_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
